// File: rtl/param_wr_arbiter_if.sv
// Write-request bus between three requesters and the parameter-bank arbiter.
// Requester side is the master; the arbiter is the slave.
interface param_wr_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 6
);
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] addr;
  logic [3*WIDTH-1:0]  din;
  logic [2:0]          ack;
  logic                err;
  logic                busy;
  logic [NREG-1:0]     wr_en;
  logic [WIDTH-1:0]    wr_d;

  modport master (
    output req, addr, din,
    input  ack, err, busy, wr_en, wr_d
  );

  modport slave (
    input  req, addr, din,
    output ack, err, busy, wr_en, wr_d
  );
endinterface

// File: rtl/param_wr_arbiter.sv
// Round-robin write arbiter: three requesters share one parameter bank.
// Every grant is IDLE -> WRITE -> ACK; all outputs come from flops.
module param_wr_arbiter #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 6
) (
  input logic               clk,
  input logic               rst,
  param_wr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_ptr, w_ptr;
  logic [1:0]        r_win, w_win;
  logic              r_bad, w_bad;
  logic [NREG-1:0]   r_wr_en, w_wr_en;
  logic [WIDTH-1:0]  r_wr_d, w_wr_d;
  logic [2:0]        r_ack, w_ack;
  logic              r_err, w_err;
  logic              r_busy, w_busy;

  logic [ADDR_W-1:0] w_a [3];
  logic [WIDTH-1:0]  w_d [3];
  logic [1:0]        w_pick;
  logic              w_found;
  logic [2:0]        w_idx;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_a[i] = bus.addr[i*ADDR_W +: ADDR_W];
      w_d[i] = bus.din[i*WIDTH +: WIDTH];
    end
  end

  // scan ptr, ptr+1, ptr+2 (mod 3); first active request wins
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int k = 0; k < 3; k++) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= 3'd3)
        w_idx = w_idx - 3'd3;
      if (!w_found && bus.req[w_idx[1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[1:0];
      end
    end
  end

  // wr_en/wr_d are loaded on the IDLE exit so they are valid during WRITE
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_win   = r_win;
    w_bad   = r_bad;
    w_wr_en = '0;
    w_wr_d  = r_wr_d;
    w_ack   = '0;
    w_err   = 1'b0;
    w_busy  = r_busy;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state = WRITE;
          w_win   = w_pick;
          w_bad   = int'(w_a[w_pick]) >= NREG;
          w_wr_d  = w_d[w_pick];
          w_busy  = 1'b1;
          for (int i = 0; i < NREG; i++)
            w_wr_en[i] = int'(w_a[w_pick]) == i;
        end
      end
      WRITE: begin
        w_state = ACK;
        w_ack   = 3'b001 << r_win;
        w_err   = r_bad;
      end
      ACK: begin
        w_state = IDLE;
        w_busy  = 1'b0;
        w_ptr   = (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_bad   <= 1'b0;
      r_wr_en <= '0;
      r_wr_d  <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_win   <= w_win;
      r_bad   <= w_bad;
      r_wr_en <= w_wr_en;
      r_wr_d  <= w_wr_d;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= w_busy;
    end
  end

  assign bus.wr_en = r_wr_en;
  assign bus.wr_d  = r_wr_d;
  assign bus.ack   = r_ack;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_param_wr_arbiter.sv
// Scoreboard bench for param_wr_arbiter: a transaction-level
// round-robin model predicts grants; a monitor checks ack/wr_en.
module tb_param_wr_arbiter;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_wr_arbiter_if #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .NREG  (NREG)
  ) bus ();

  param_wr_arbiter #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .NREG  (NREG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         win;
    int         a;
    logic [7:0] d;
    bit         bad;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         mptr = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  int         last_wr_cyc = 0;
  logic [5:0] last_wr_en;
  logic [7:0] last_wr_d;
  int         gaps[$];

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  function automatic logic [5:0] oh(int a);
    return (a < NREG) ? (6'(1) << a) : 6'd0;
  endfunction

  // monitor: compares every DUT ack against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr_cnt = 0;
        continue;
      end
      cyc++;
      if (bus.wr_en != 0) begin
        chk("wr_en_onehot", 32'($onehot(bus.wr_en)), 1);
        wr_cnt++;
        last_wr_en = bus.wr_en;
        last_wr_d  = bus.wr_d;
        gaps.push_back(cyc - last_wr_cyc);
        last_wr_cyc = cyc;
      end
      if (bus.ack != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack), 0);
        end else begin
          e = sb.pop_front();
          chk("ack_winner", 32'(bus.ack), 32'(1) << e.win);
          chk("ack_err", 32'(bus.err), 32'(e.bad));
          chk("wr_pulses", wr_cnt, e.bad ? 0 : 1);
          if (!e.bad) begin
            chk("wr_en_addr", 32'(last_wr_en), 32'(oh(e.a)));
            chk("wr_d", 32'(last_wr_d), 32'(e.d));
          end
        end
        wr_cnt = 0;
      end else if (bus.err) begin
        chk("err_without_ack", 32'(bus.err), 0);
      end
    end
  end

  task automatic set_req(int i, int a, logic [7:0] d);
    bus.addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    bus.din[i*WIDTH +: WIDTH]    = d;
  endtask

  // reference: requesters hold until acked, grants rotate from mptr
  task automatic plan(input logic [2:0] m);
    logic [2:0] p;
    int         j;
    exp_t       e;
    p = m;
    while (p != 0) begin
      for (int k = 0; k < 3; k++) begin
        j = (mptr + k) % 3;
        if (p[j]) begin
          e.win = j;
          e.a   = int'(bus.addr[j*ADDR_W +: ADDR_W]);
          e.d   = bus.din[j*WIDTH +: WIDTH];
          e.bad = e.a >= NREG;
          sb.push_back(e);
          p[j] = 1'b0;
          mptr = (j + 1) % 3;
          break;
        end
      end
    end
  endtask

  task automatic wait_done(string n);
    int t = 0;
    while ((bus.req != 0 || sb.size() != 0) && t < 60) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < 3; i++)
        if (bus.ack[i]) bus.req[i] = 1'b0;
    end
    if (t >= 60) chk({n, "_timeout"}, 1, 0);
  endtask

  task automatic issue(logic [2:0] m, string n);
    bus.req = m;
    plan(m);
    wait_done(n);
  endtask

  task automatic wait_wr(string n);
    int t = 0;
    while (bus.wr_en == 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) chk({n, "_wr_timeout"}, 1, 0);
  endtask

  initial begin
    bus.req  = '0;
    bus.addr = '0;
    bus.din  = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_d", 32'(bus.wr_d), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // single request, exact latency
    set_req(0, 2, 8'hA5);
    bus.req = 3'b001;
    plan(3'b001);
    @(negedge clk);
    chk("s1_wr_en", 32'(bus.wr_en), 32'(6'b000100));
    chk("s1_wr_d", 32'(bus.wr_d), 32'h A5);
    chk("s1_busy1", 32'(bus.busy), 1);
    @(negedge clk);
    chk("s1_ack", 32'(bus.ack), 32'(3'b001));
    chk("s1_busy2", 32'(bus.busy), 1);
    chk("s1_wr_en_off", 32'(bus.wr_en), 0);
    bus.req = 3'b000;
    @(negedge clk);
    chk("s1_busy_off", 32'(bus.busy), 0);
    chk("s1_ack_off", 32'(bus.ack), 0);

    // ptr=1: requester 2 beats requester 0
    set_req(0, 1, 8'h11);
    set_req(2, 3, 8'h22);
    issue(3'b101, "s034");
    set_req(2, 0, 8'h33);
    issue(3'b100, "s_ptr0");

    // all three at once from ptr=0
    gaps.delete();
    set_req(0, 0, 8'h40);
    set_req(1, 1, 8'h41);
    set_req(2, 5, 8'h42);
    issue(3'b111, "s033");
    chk("s033_pulses", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("s033_gap1", gaps[1], 3);
      chk("s033_gap2", gaps[2], 3);
    end

    // out-of-range address
    set_req(1, 7, 8'h3C);
    issue(3'b010, "s035");

    // request withdrawn while writing
    set_req(0, 4, 8'h5A);
    bus.req = 3'b001;
    plan(3'b001);
    @(negedge clk);
    wait_wr("s037");
    bus.req = 3'b000;
    wait_done("s037");

    // asynchronous reset in the middle of WRITE
    set_req(1, 5, 8'h77);
    bus.req = 3'b010;
    plan(3'b010);
    @(negedge clk);
    wait_wr("s036");
    #2 rst = 1'b0;
    #1;
    chk("s036_wr_en", 32'(bus.wr_en), 0);
    chk("s036_busy", 32'(bus.busy), 0);
    chk("s036_ack", 32'(bus.ack), 0);
    sb.delete();
    mptr = 0;
    bus.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    set_req(0, 3, 8'h81);
    set_req(2, 2, 8'h82);
    issue(3'b101, "s036_ptr0");
    set_req(1, 1, 8'h90);
    issue(3'b010, "s036_r1");

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++)
        set_req(i, $urandom_range(0, 7), 8'($urandom));
      issue(3'($urandom_range(1, 7)), "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/param_wr_arbiter.md
PARAM_WR_ARBITER -- requirements
Module: param_wr_arbiter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data width of every parameter register in the bank.
REQ-002 The block SHALL take parameter ADDR_W, default 3, as the register address width.
REQ-003 The block SHALL take parameter NREG, default 6, as the number of implemented registers; NREG SHALL be at most 2**ADDR_W.
REQ-004 Port clk SHALL be an input, 1 bit, the single system clock; all state SHALL change on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit, the reset: asynchronous and active-low.
REQ-006 Port req SHALL be an input, 3 bits, write requests; bit 0 is the host command port, bit 1 the scan engine, bit 2 the calibration engine.
REQ-007 Port addr SHALL be an input, 3*ADDR_W bits, the target register address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 Port din SHALL be an input, 3*WIDTH bits, the write data; requester i uses slice [i*WIDTH +: WIDTH].
REQ-009 Port ack SHALL be an output, 3 bits, a one-cycle completion pulse per requester.
REQ-010 Port err SHALL be an output, 1 bit, pulsed together with ack when the serviced address is at or above NREG.
REQ-011 Port busy SHALL be an output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 Port wr_en SHALL be an output, NREG bits, one-hot enables wired to the en inputs of the bank registers.
REQ-013 Port wr_d SHALL be an output, WIDTH bits, shared write data wired to the d inputs of the bank registers.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have exactly three states: IDLE, WRITE and ACK.
REQ-016 IDLE: when req is nonzero, the FSM SHALL select a winner by round-robin starting from ptr, latch the winner's index, addr and din, and go to WRITE.
REQ-017 IDLE: when req is zero, the FSM SHALL stay in IDLE.
REQ-018 WRITE: for exactly one cycle, the FSM SHALL drive wr_en[latched addr]=1 with all other bits 0, drive wr_d = latched data, then go to ACK.
REQ-019 WRITE with latched addr >= NREG: wr_en SHALL stay all-zero and the err flag SHALL be set for the ACK state.
REQ-020 ACK: for exactly one cycle, the FSM SHALL drive ack[winner]=1, and err if flagged.
REQ-021 ACK: the FSM SHALL set ptr = (winner+1) mod 3, then return to IDLE.
REQ-022 wr_d SHALL hold its last value outside WRITE; wr_en, ack and err SHALL be zero outside their respective states.
REQ-023 Round-robin order SHALL be ptr, ptr+1, ptr+2 (mod 3); the first requester with req=1 in that order wins.
REQ-024 Throughput SHALL be one write per 3 cycles; the latency from req sampled in IDLE to the wr_en pulse SHALL be 1 cycle, and to ack 2 cycles.
REQ-025 Requesters SHALL hold req, addr and din stable until ack and drop req on the edge after ack; the arbiter SHALL sample req only in IDLE.
REQ-026 A req withdrawn after being latched SHALL NOT abort the write; the write SHALL complete and ack SHALL still pulse.
REQ-027 Simultaneous requests SHALL be served one per WRITE/ACK cycle with no loss and no duplicate write.
REQ-028 At most one bit of wr_en and at most one bit of ack SHALL be high in any cycle.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, ptr=0, wr_en=0, wr_d=0, ack=0, err=0 and busy=0, independent of clk.
REQ-030 Reset asserted during WRITE SHALL clear wr_en within the same cycle; the pending write SHALL be discarded without ack.
REQ-031 After rst returns high, the first grant SHALL use ptr=0.

Verification
REQ-032 The bench SHALL cover: reset release, then req=001, addr0=2, din0=8'hA5 -> wr_en=000100 and wr_d=A5 one cycle later, then ack=001 on the following cycle, with busy high for 2 cycles.
REQ-033 The bench SHALL cover: req=111 held with each requester dropping its req after its ack -> grants in order 0,1,2, with wr_en pulses 3 cycles apart and no repeated grant.
REQ-034 The bench SHALL cover: ptr=1 after serving 0, then req=101 -> requester 2 wins before requester 0.
REQ-035 The bench SHALL cover: addr1=7 with NREG=6 -> wr_en=0 throughout, and ack=010 with err=1 in the same cycle.
REQ-036 The bench SHALL cover: rst=0 asynchronously mid-WRITE -> wr_en=0 before the next clk edge and no ack; after release, req=010 is served with ptr=0.
REQ-037 The bench SHALL cover: req dropped during WRITE -> the write still lands and ack still pulses.
